multiplier_core: RTL and testbench
==================================

MULTIPLIER_CORE -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have parameter SIZE, default 24, giving the operand width in bits (24 = float32 mantissa plus hidden bit).
REQ-002 Port clk SHALL be an input, 1 bit, and is the single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit; reset is synchronous and active-high.
REQ-004 Port in_valid SHALL be an input, 1 bit, and qualifies a and b for capture.
REQ-005 Port a SHALL be an input, SIZE bits, carrying the unsigned multiplicand.
REQ-006 Port b SHALL be an input, SIZE bits, carrying the unsigned multiplier.
REQ-007 Port out SHALL be an output, 2*SIZE bits, carrying the registered unsigned product.
REQ-008 Port out_valid SHALL be an output, 1 bit, and is high when out holds a newly computed product.

Function
REQ-009 Product arithmetic: out SHALL equal a*b, unsigned, at full 2*SIZE width, with no truncation, rounding or saturation.
REQ-010 Width bound: (2^SIZE-1)^2 fits in 2*SIZE bits, so no overflow flag SHALL exist.
REQ-011 Partial products: partial product i (i = 0..SIZE-1) SHALL be produced by a 2-input mux selected by b[i].
- in[0] = 0.
- in[1] = a zero-extended to 2*SIZE bits and shifted left by i.
REQ-012 Summation: the SIZE partial products SHALL be summed combinationally at 2*SIZE width, as an adder chain or tree.
REQ-013 Latency: on a rising edge with in_valid=1 and reset=0, the core SHALL register out <= a*b and out_valid <= 1, so the result appears exactly 1 cycle after capture.
REQ-014 Idle cycles: on a rising edge with in_valid=0 and reset=0, out SHALL hold its previous value and out_valid SHALL go to 0.
REQ-015 Throughput: the core SHALL accept one operand pair per cycle, and back-to-back valid inputs SHALL produce back-to-back out_valid pulses in input order.
REQ-016 Flow control: there SHALL be no backpressure and no ready signal; a result not consumed in its valid cycle remains on out until the next accepted input or reset.
REQ-017 Reset priority: reset SHALL take priority over in_valid on the same edge, and the operand pair presented on that edge is discarded.
REQ-018 Minimum width: SIZE=1 SHALL be supported, giving a 2-bit out equal to a AND b in bit 0 and 0 in bit 1.
REQ-019 Mux contract: the mux SHALL be purely combinational with out = in[port].
- Parameters: DATA_SIZE and SELECT_SIZE.
- Ports: in, an unpacked array of 2^SELECT_SIZE words of DATA_SIZE bits; port, SELECT_SIZE bits; out, DATA_SIZE bits.

Reset
REQ-020 While reset is sampled high, out SHALL become 0 and out_valid SHALL become 0 on the next rising edge.
REQ-021 No other state SHALL exist in the block.
REQ-022 Reset asserted mid-stream SHALL drop any result not yet registered.
REQ-023 After reset deasserts, the first valid input SHALL produce out_valid exactly one cycle later.

Structure
REQ-024 The multiplier SHALL instantiate the sub-module mux, SIZE times, with DATA_SIZE=2*SIZE and SELECT_SIZE=1.
REQ-025 The mux SHALL be a separate, reusable module, because the float multiplier also uses it with SELECT_SIZE=1 for exponent and mantissa normalization selection.
REQ-026 The shared package SHALL hold the float32 constants: FLOAT_SIZE=32, EXPONENT_SIZE=8, MANTISSA_SIZE=23, BIAS=127.
REQ-027 The multiplier default SIZE SHALL be defined from that package as MANTISSA_SIZE+1.
REQ-028 The package SHALL contain no multiplier-internal typedefs.

Verification (SIZE=24 unless stated)
REQ-029 The bench SHALL cover the 1.0 x 1.0 case: a=b=0x800000, in_valid=1 -> next cycle out=0x400000000000, out[47]=0, out[46]=1, out_valid=1.
REQ-030 The bench SHALL cover the maximum operands: a=b=0xFFFFFF -> out=0xFFFFFE000001 and out[47]=1.
REQ-031 The bench SHALL cover the zero and hold cases:
- a=0, b=0xABCDEF -> out=0.
- in_valid=0 on the following cycle -> out holds 0 and out_valid=0.
REQ-032 The bench SHALL cover back-to-back input: (3,5), (0x800001,0x800001), (7,0) on consecutive cycles -> out_valid high for 3 cycles with out = 0xF, then 0x400001000001, then 0.
REQ-033 The bench SHALL cover reset mid-stream: reset=1 and in_valid=1 with a=b=2 on the same edge -> out=0 and out_valid=0 next cycle.
REQ-034 The bench SHALL cover a standalone mux: SELECT_SIZE=2, DATA_SIZE=8, in={0x11,0x22,0x33,0x44}, port=2 -> out=0x33.
REQ-035 The bench SHALL run 1000 random a, b pairs and compare each result against a reference product computed at 2*SIZE width.

Source files
------------

// File: rtl/multiplier_core_pkg.sv
// Shared float32 constants used by the multiplier and the float datapath.
// Only format-level constants live here; the multiplier's internals stay
// local to its own module.
package multiplier_core_pkg;

    localparam int FLOAT_SIZE    = 32;
    localparam int EXPONENT_SIZE = 8;
    localparam int MANTISSA_SIZE = 23;
    localparam int BIAS          = 127;

endpackage

// File: rtl/multiplier_core_mux.sv
// Generic combinational N-way word selector.
// Ports:
//   in   - 2**SELECT_SIZE candidate words, DATA_SIZE bits each
//   port - SELECT_SIZE-bit select
//   out  - selected word, out = in[port]
// Reused by the float multiplier for exponent / mantissa normalization
// selection, so it carries no multiplier-specific knowledge.
module multiplier_core_mux #(
    parameter int DATA_SIZE   = 8,
    parameter int SELECT_SIZE = 1
) (
    input  logic [DATA_SIZE-1:0]   in [2**SELECT_SIZE],
    input  logic [SELECT_SIZE-1:0] port,
    output logic [DATA_SIZE-1:0]   out
);

    assign out = in[port];

endmodule

// File: rtl/multiplier_core.sv
// Unsigned SIZE x SIZE shift-and-add multiplier with a single output register.
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset, wins over in_valid
//   in_valid  - qualifies a/b for capture
//   a, b      - unsigned operands, SIZE bits
//   out       - registered full-width product, 2*SIZE bits (never overflows)
//   out_valid - high for one cycle per captured operand pair
// Partial product i is a or zero, selected by b[i]; the partial products are
// summed combinationally and the sum is registered on capture. When idle the
// last product stays on out.
module multiplier_core
    import multiplier_core_pkg::*;
#(
    parameter int SIZE = MANTISSA_SIZE + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] out,
    output logic              out_valid
);

    localparam int PROD_SIZE = 2 * SIZE;

    logic [PROD_SIZE-1:0] partial [SIZE];
    logic [PROD_SIZE-1:0] product_sum;
    logic [PROD_SIZE-1:0] out_reg;
    logic                 out_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : gen_partial
            logic [PROD_SIZE-1:0] mux_in [2];

            assign mux_in[0] = '0;
            assign mux_in[1] = {{SIZE{1'b0}}, a} << gi;

            multiplier_core_mux #(
                .DATA_SIZE   (PROD_SIZE),
                .SELECT_SIZE (1)
            ) u_mux (
                .in   (mux_in),
                .port (b[gi]),
                .out  (partial[gi])
            );
        end
    endgenerate

    // Linear adder chain; synthesis is free to rebalance it into a tree.
    always_comb begin
        product_sum = '0;
        for (int i = 0; i < SIZE; i++) begin
            product_sum = product_sum + partial[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_reg <= product_sum;
            end
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_multiplier_core.sv
module tb_multiplier_core;

    localparam int SIZE = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic [2*SIZE-1:0] out;
    logic              out_valid;

    // One-bit instance for the minimum-width case
    logic              in_valid1;
    logic [0:0]        a1;
    logic [0:0]        b1;
    logic [1:0]        out1;
    logic              out_valid1;

    // Standalone 4-way selector
    logic [7:0]        mux_in [4];
    logic [1:0]        mux_port;
    logic [7:0]        mux_out;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];
    logic [63:0] last_out;

    always #5 clk = ~clk;

    multiplier_core #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    multiplier_core #(.SIZE(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .out       (out1),
        .out_valid (out_valid1)
    );

    multiplier_core_mux #(.DATA_SIZE(8), .SELECT_SIZE(2)) dut_mux (
        .in   (mux_in),
        .port (mux_port),
        .out  (mux_out)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end else begin
            $display("ok   %s 0x%0h", tag, got);
        end
    endtask

    // Drive one cycle of stimulus, push the reference product, then sample
    // 1 time unit after the edge and score the DUT output.
    task automatic step(input string tag, input logic v, input logic [SIZE-1:0] av,
                        input logic [SIZE-1:0] bv, input logic r);
        logic [63:0] ea;
        logic [63:0] eb;
        logic        exp_valid;
        ea = {40'd0, av};
        eb = {40'd0, bv};
        in_valid = v;
        a        = av;
        b        = bv;
        reset    = r;
        exp_valid = v && !r;
        if (exp_valid) exp_q.push_back(ea * eb);
        if (r) last_out = 64'd0;
        @(posedge clk);
        #1;
        check_value({tag, ".valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_value({tag, ".sb_empty"}, 64'd1, 64'd0);
            end else begin
                last_out = exp_q.pop_front();
                check_value({tag, ".out"}, {16'd0, out}, last_out);
            end
        end else begin
            check_value({tag, ".hold"}, {16'd0, out}, last_out);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_valid1 = 1'b0;
        a1        = '0;
        b1        = '0;
        mux_port  = '0;
        mux_in[0] = 8'h11;
        mux_in[1] = 8'h22;
        mux_in[2] = 8'h33;
        mux_in[3] = 8'h44;
        last_out  = 64'd0;
        #2;

        step("reset0", 1'b0, 24'd0, 24'd0, 1'b1);
        step("reset1", 1'b1, 24'h123456, 24'h654321, 1'b1);

        step("one_x_one", 1'b1, 24'h800000, 24'h800000, 1'b0);
        check_value("one_x_one.bit47", {63'd0, out[47]}, 64'd0);
        check_value("one_x_one.bit46", {63'd0, out[46]}, 64'd1);
        check_value("one_x_one.const", {16'd0, out}, 64'h400000000000);

        step("max", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
        check_value("max.bit47", {63'd0, out[47]}, 64'd1);
        check_value("max.const", {16'd0, out}, 64'hFFFFFE000001);

        step("zero", 1'b1, 24'd0, 24'hABCDEF, 1'b0);
        step("idle", 1'b0, 24'h111111, 24'h222222, 1'b0);
        check_value("idle.const", {16'd0, out}, 64'd0);

        step("b2b0", 1'b1, 24'd3, 24'd5, 1'b0);
        check_value("b2b0.const", {16'd0, out}, 64'hF);
        step("b2b1", 1'b1, 24'h800001, 24'h800001, 1'b0);
        check_value("b2b1.const", {16'd0, out}, 64'h400001000001);
        step("b2b2", 1'b1, 24'd7, 24'd0, 1'b0);
        step("pre_rst", 1'b1, 24'h00ABCD, 24'h001234, 1'b0);

        step("mid_rst", 1'b1, 24'd2, 24'd2, 1'b1);
        check_value("mid_rst.const", {16'd0, out}, 64'd0);
        step("post_rst", 1'b1, 24'd9, 24'd11, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            step("rand", ($urandom_range(0, 7) != 0), 24'($urandom()), 24'($urandom()), 1'b0);
        end
        step("drain", 1'b0, 24'd0, 24'd0, 1'b0);
        check_value("sb_left", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab        = 2'(i);
            in_valid1 = 1'b1;
            a1        = ab[0];
            b1        = ab[1];
            @(posedge clk);
            #1;
            check_value("size1.valid", {63'd0, out_valid1}, 64'd1);
            check_value("size1.out", {62'd0, out1}, {62'd0, 1'b0, ab[0] & ab[1]});
        end

        mux_port = 2'd2;
        #1;
        check_value("mux4.sel2", {56'd0, mux_out}, 64'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
